// File: rtl/pixel_feeder_if.sv
// Memory read port and pixel stream between pixel_feeder and its neighbours.
interface pixel_feeder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic signed [8:0] mem_data;
    logic signed [8:0] pix_out;
    logic              pix_valid;
    logic              win_valid;

    modport master (
        output mem_rd_en, mem_addr, pix_out, pix_valid, win_valid,
        input  mem_data
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_out, pix_valid, win_valid,
        output mem_data
    );
endinterface

// File: rtl/pixel_feeder.sv
// Streams one IMAGE_WIDTH x IMAGE_WIDTH frame from memory into the line-buffer chain.
// Define FEEDER_COORD_EN to add pix_row/pix_col coordinate outputs.
module pixel_feeder #(
    parameter int unsigned IMAGE_WIDTH  = 28,
    parameter int unsigned KERNEL_WIDTH = 5,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic              busy,
    output logic              done,
`ifdef FEEDER_COORD_EN
    output logic [ADDR_W-1:0] pix_row,
    output logic [ADDR_W-1:0] pix_col,
`endif
    pixel_feeder_if.master    bus
);

    localparam int unsigned NPIX  = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned CRD_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  px_cnt_q, px_cnt_d;
    logic [CRD_W-1:0]  row_q, row_d;
    logic [CRD_W-1:0]  col_q, col_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              rd_pipe_q, rd_pipe_d;
    logic signed [8:0] pix_out_q, pix_out_d;
    logic              pix_valid_q, pix_valid_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef FEEDER_COORD_EN
    logic [CRD_W-1:0]  pix_row_q, pix_row_d;
    logic [CRD_W-1:0]  pix_col_q, pix_col_d;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        rd_cnt_d    = rd_cnt_q;
        px_cnt_d    = px_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        mem_rd_en_d = 1'b0;
        rd_pipe_d   = mem_rd_en_q;
        pix_out_d   = pix_out_q;
        pix_valid_d = rd_pipe_q;
        win_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef FEEDER_COORD_EN
        pix_row_d   = pix_row_q;
        pix_col_d   = pix_col_q;
`endif

        // Output side: mem_data is valid the cycle after the strobe, register it out.
        if (rd_pipe_q) begin
            pix_out_d   = bus.mem_data;
            win_valid_d = (row_q >= CRD_W'(KERNEL_WIDTH - 1)) &&
                          (col_q >= CRD_W'(KERNEL_WIDTH - 1));
            px_cnt_d    = px_cnt_q + CNT_W'(1);
`ifdef FEEDER_COORD_EN
            pix_row_d   = row_q;
            pix_col_d   = col_q;
`endif
            if (col_q == CRD_W'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                row_d = row_q + CRD_W'(1);
            end else begin
                col_d = col_q + CRD_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    rd_cnt_d = '0;
                    px_cnt_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'(rd_cnt_q);
                    rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == CNT_W'(NPIX - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pix_valid_q && (px_cnt_q == CNT_W'(NPIX))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            rd_cnt_q    <= '0;
            px_cnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mem_rd_en_q <= 1'b0;
            rd_pipe_q   <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FEEDER_COORD_EN
            pix_row_q   <= '0;
            pix_col_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            px_cnt_q    <= px_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mem_rd_en_q <= mem_rd_en_d;
            rd_pipe_q   <= rd_pipe_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FEEDER_COORD_EN
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
`endif
        end
    end

    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.pix_out   = pix_out_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.win_valid = win_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef FEEDER_COORD_EN
    assign pix_row       = ADDR_W'(pix_row_q);
    assign pix_col       = ADDR_W'(pix_col_q);
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed frame-level bench for pixel_feeder against a ramp memory (data = addr mod 256).
module tb_pixel_feeder;

    localparam int AW = 10;
    localparam int IW = 28;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          stall;
    logic          busy;
    logic          done;
`ifdef FEEDER_COORD_EN
    logic [AW-1:0] pix_row;
    logic [AW-1:0] pix_col;
`endif

    pixel_feeder_if #(.ADDR_W(AW)) bus ();

    pixel_feeder #(.IMAGE_WIDTH(IW), .KERNEL_WIDTH(5), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
`ifdef FEEDER_COORD_EN
        .pix_row   (pix_row),
        .pix_col   (pix_col),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Ramp memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_data <= $signed({1'b0, bus.mem_addr[7:0]});
    end

    int total = 0;
    int bad   = 0;

    int t, rd_idx, pix_idx, win_cnt, first_win, first_pv, done_cnt, done_t;
    int addr_err, pix_err, hold_err, stall_err, orphan_err, coord_err, busy_err;
    int active;
    logic [AW-1:0]     cur_base;
    logic signed [8:0] last_pix;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon(input logic [AW-1:0] b);
        t = -1; rd_idx = 0; pix_idx = 0; win_cnt = 0; first_win = -1; first_pv = -1;
        done_cnt = 0; done_t = -1; addr_err = 0; pix_err = 0; hold_err = 0;
        stall_err = 0; orphan_err = 0; coord_err = 0; busy_err = 0;
        cur_base = b; active = 1;
    endtask

    // Advance one clock and score everything visible after the edge.
    task automatic step();
        logic          st_e, rs_e;
        logic [AW-1:0] ea;
        logic signed [8:0] ep;
        st_e = stall;
        rs_e = reset;
        @(posedge clk);
        #1;
        t++;
        if (rs_e) last_pix = '0;
        if (bus.mem_rd_en) begin
            if (st_e) stall_err++;
            ea = AW'(cur_base + AW'(rd_idx));
            if (bus.mem_addr !== ea) addr_err++;
            rd_idx++;
        end
        if (bus.pix_valid) begin
            ea = AW'(cur_base + AW'(pix_idx));
            ep = $signed({1'b0, ea[7:0]});
            if (bus.pix_out !== ep) pix_err++;
`ifdef FEEDER_COORD_EN
            if (pix_row !== AW'(pix_idx / IW) || pix_col !== AW'(pix_idx % IW)) coord_err++;
`endif
            if (first_pv < 0) first_pv = t;
            pix_idx++;
            last_pix = bus.pix_out;
        end else if (!rs_e && bus.pix_out !== last_pix) begin
            hold_err++;
        end
        if (bus.win_valid) begin
            if (!bus.pix_valid) orphan_err++;
            win_cnt++;
            if (first_win < 0) first_win = pix_idx;
        end
        if (done) begin
            done_cnt++;
            if (done_t < 0) done_t = t;
            if (busy) busy_err++;
        end else if (active != 0 && done_t < 0 && !busy) begin
            busy_err++;
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int stall_at;
        int stall_len;
        int restart_at;
        int exp_first_pv;
        int exp_done_t;
        int exp_pix;
        int exp_win;
        int exp_first_win;
    } vec_t;

    vec_t vec [5];

    initial begin
        int n;
        vec[0] = '{10'd0,    -1, 0,  -1, 3, 787, 784, 576, 117};
        vec[1] = '{10'd0,    100, 10, -1, 3, 797, 784, 576, 117};
        vec[2] = '{10'd0,    -1, 0,  50, 3, 787, 784, 576, 117};
        vec[3] = '{10'd1020, -1, 0,  -1, 3, 787, 784, 576, 117};
        vec[4] = '{10'd0,    0,  5,  -1, 8, 792, 784, 576, 117};

        reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0;
        last_pix = '0;
        clear_mon('0);
        active = 0;
        step(); step();
        chk("reset_ctrl", int'({bus.mem_rd_en, bus.pix_valid, bus.win_valid, busy, done}), 0);
        chk("reset_pix", int'(bus.pix_out), 0);

        start = 1'b1;
        step();
        chk("reset_over_start", int'(busy), 0);
        start = 1'b0; reset = 1'b0;
        step();
        chk("idle_no_start", int'({busy, bus.mem_rd_en}), 0);

        // Reset in the middle of a frame at pixel 300.
        clear_mon('0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (pix_idx < 300 && n < 1000) begin step(); n++; end
        chk("mid_reached_300", pix_idx, 300);
        chk("mid_pix_err", pix_err + addr_err, 0);
        active = 0;
        reset = 1'b1;
        step();
        chk("mid_reset_ctrl", int'({bus.mem_rd_en, bus.pix_valid, bus.win_valid, busy, done}), 0);
        chk("mid_reset_pix", int'(bus.pix_out), 0);
        reset = 1'b0;
        n = pix_idx;
        for (int i = 0; i < 6; i++) step();
        chk("mid_no_pv_after", pix_idx - n, 0);
        chk("mid_no_done_after", done_cnt, 0);

        // Full frames, the first of which is the clean frame after the reset.
        for (int v = 0; v < 5; v++) begin
            clear_mon(vec[v].base);
            base_addr = vec[v].base;
            stall = (vec[v].stall_at == 0 && vec[v].stall_len > 0);
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (n < 3000 && !(done_t >= 0 && t >= done_t + 4)) begin
                stall = (t >= vec[v].stall_at && t < vec[v].stall_at + vec[v].stall_len);
                start = (t == vec[v].restart_at);
                step();
                n++;
            end
            start = 1'b0; stall = 1'b0;
            chk($sformatf("v%0d_first_pv", v), first_pv, vec[v].exp_first_pv);
            chk($sformatf("v%0d_done_t", v), done_t, vec[v].exp_done_t);
            chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            chk($sformatf("v%0d_pix_cnt", v), pix_idx, vec[v].exp_pix);
            chk($sformatf("v%0d_rd_cnt", v), rd_idx, vec[v].exp_pix);
            chk($sformatf("v%0d_win_cnt", v), win_cnt, vec[v].exp_win);
            chk($sformatf("v%0d_first_win", v), first_win, vec[v].exp_first_win);
            chk($sformatf("v%0d_addr_err", v), addr_err, 0);
            chk($sformatf("v%0d_pix_err", v), pix_err, 0);
            chk($sformatf("v%0d_hold_err", v), hold_err, 0);
            chk($sformatf("v%0d_stall_err", v), stall_err, 0);
            chk($sformatf("v%0d_misc_err", v), orphan_err + coord_err + busy_err, 0);
            chk($sformatf("v%0d_idle_after", v), int'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
